// File: rtl/aspiradora_pkg.sv
// Shared switch indices, one-hot command type and the fixed-priority arbiter
// used by the vacuum-cleaner front end.
package aspiradora_pkg;

  localparam int N_SW         = 4;
  localparam int SW_POWER_OFF = 0;
  localparam int SW_ON        = 1;
  localparam int SW_CLEANING  = 2;
  localparam int SW_EVADING   = 3;

  typedef logic [N_SW-1:0] cmd_t;

  localparam cmd_t CMD_NONE = 4'b0000;

  // Priority order: power_off > evading > cleaning > on.
  function automatic cmd_t arbitrate(input cmd_t rise);
    cmd_t win;
    win = CMD_NONE;
    if (rise[SW_POWER_OFF])     win[SW_POWER_OFF] = 1'b1;
    else if (rise[SW_EVADING])  win[SW_EVADING]   = 1'b1;
    else if (rise[SW_CLEANING]) win[SW_CLEANING]  = 1'b1;
    else if (rise[SW_ON])       win[SW_ON]        = 1'b1;
    return win;
  endfunction

  function automatic logic multi_hot(input cmd_t v);
    return (v & (v - cmd_t'(1))) != CMD_NONE;
  endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Command bus from the switch conditioner to the vacuum-cleaner FSM.
import aspiradora_pkg::*;

interface switch_conditioner_if;
  cmd_t       cmd;
  logic       cmd_valid;
  logic       cmd_drop;
  logic [7:0] evt_count;

  modport master (output cmd, cmd_valid, cmd_drop, evt_count);
  modport slave  (input  cmd, cmd_valid, cmd_drop, evt_count);
endinterface

// File: rtl/switch_debounce_ch.sv
// One switch channel: two-flop synchroniser followed by a stable-count
// debouncer that only accepts a level held for DEBOUNCE_CYCLES cycles.
module switch_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input matches the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/switch_conditioner.sv
// Switch front end: per-channel debounce, rising-edge detect and fixed-priority
// one-hot command pulse. Define SWCOND_EVT_COUNT_EN to build the event counter.
import aspiradora_pkg::*;

module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_SW-1:0]        sw_raw,
  output logic [N_SW-1:0]        sw_level,
  switch_conditioner_if.master   cmd_bus
);

  logic [N_SW-1:0] level_w;
  logic [N_SW-1:0] sw_level_q;
  cmd_t            rise;
  cmd_t            cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            cmd_drop_q, cmd_drop_d;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw_i (sw_raw[g]),
      .level_o  (level_w[g])
    );
  end

  assign sw_level = level_w;
  assign rise     = level_w & ~sw_level_q;

  // Edges seen while disabled are discarded, not held for later.
  always_comb begin
    cmd_d       = CMD_NONE;
    cmd_drop_d  = 1'b0;
    if (ena) begin
      cmd_d      = arbitrate(rise);
      cmd_drop_d = multi_hot(rise);
    end
    cmd_valid_d = (cmd_d != CMD_NONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_level_q  <= '0;
      cmd_q       <= CMD_NONE;
      cmd_valid_q <= 1'b0;
      cmd_drop_q  <= 1'b0;
    end else begin
      sw_level_q  <= level_w;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_drop_q  <= cmd_drop_d;
    end
  end

  assign cmd_bus.cmd       = cmd_q;
  assign cmd_bus.cmd_valid = cmd_valid_q;
  assign cmd_bus.cmd_drop  = cmd_drop_q;

`ifdef SWCOND_EVT_COUNT_EN
  logic [7:0] evt_count_q, evt_count_d;

  assign evt_count_d = cmd_valid_q ? evt_count_q + 8'd1 : evt_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) evt_count_q <= 8'h00;
    else        evt_count_q <= evt_count_d;
  end

  assign cmd_bus.evt_count = evt_count_q;
`else
  assign cmd_bus.evt_count = 8'h00;
`endif

endmodule
